// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter for SRL/SRA: one bit per clock, logical or arithmetic fill.
// Result is registered separately so data_out never exposes partial shifts.
module shift_right_seq #(
  parameter int N  = 16,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          arith,
  input  logic [N-1:0]  data_in,
  input  logic [SW-1:0] shamt,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  data_out
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  work_q, work_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          arith_q, arith_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] amt;
  logic [N-1:0]  shifted;
  logic          accept;

  // Amounts at or beyond the width saturate to N single-bit steps.
  assign amt     = (32'(shamt) >= N) ? CW'(N) : CW'(shamt);
  assign accept  = start && (state_q != SHIFT);
  assign shifted = {arith_q & work_q[N-1], work_q[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      dout_q  <= '0;
      arith_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
      arith_q <= arith_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dout_d  = dout_q;
    arith_d = arith_q;
    cnt_d   = cnt_q;
    if (accept) begin
      work_d  = data_in;
      arith_d = arith;
      cnt_d   = amt;
      if (amt == '0) begin
        dout_d  = data_in;
        state_d = DONE;
      end else begin
        state_d = SHIFT;
      end
    end else begin
      case (state_q)
        SHIFT: begin
          work_d = shifted;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            dout_d  = shifted;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign data_out = dout_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Randomised and directed bench for shift_right_seq against a timing/result model
// that computes each result in one step with whole-word shifts.
module tb_shift_right_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        arith;
  logic [15:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [15:0] data_out;

  int nvec = 0;
  int nerr = 0;

  shift_right_seq #(.N(16), .SW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .arith(arith),
    .data_in(data_in), .shamt(shamt),
    .busy(busy), .done(done), .data_out(data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: an op accepted at edge k with amount a is busy after edges k..k+a-1
  // and completes (done, new data_out) after edge k+a.
  int          m_edge = 0;
  int          m_end  = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_out  = '0;
  logic [15:0] m_res  = '0;

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int a, input logic ar);
    logic [15:0] mask;
    mask = 16'hFFFF;
    mask = ~(mask >> a);
    return (d >> a) | ((ar && d[15]) ? mask : 16'h0000);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_out  = '0;
    end else begin
      int a;
      m_edge++;
      if (m_busy) begin
        m_done = 1'b0;
        if (m_edge == m_end) begin
          m_out  = m_res;
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        a     = (int'(shamt) >= 16) ? 16 : int'(shamt);
        m_res = ref_shift(data_in, a, arith);
        if (a == 0) begin
          m_out  = m_res;
          m_done = 1'b1;
        end else begin
          m_end  = m_edge + a;
          m_busy = 1'b1;
          m_done = 1'b0;
        end
      end else begin
        m_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      nvec++;
      if ({busy, done, data_out} !== {m_busy, m_done, m_out}) begin
        nerr++;
        $display("FAIL cycle_cmp t=%0t got busy=%b done=%b out=%h want busy=%b done=%b out=%h",
                 $time, busy, done, data_out, m_busy, m_done, m_out);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; start is presented for one cycle, then the inputs are scrambled.
  task automatic op(input logic [15:0] d, input logic [4:0] s, input logic ar,
                    input logic [15:0] expv, input int explat, input logic poke, input string nm);
    int lat;
    int nb;
    data_in = d; shamt = s; arith = ar; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data_in = 16'($urandom); shamt = 5'($urandom); arith = 1'($urandom);
    lat = 0; nb = 0;
    while (!done && lat < 100) begin
      if (busy) nb++;
      if (poke) begin
        start = 1'($urandom);
        data_in = 16'($urandom); shamt = 5'($urandom); arith = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({nm, "_lat"}, 32'(lat), 32'(explat));
    chk({nm, "_busy"}, 32'(nb), 32'(explat));
    chk({nm, "_out"}, {16'h0, data_out}, {16'h0, expv});
    chk({nm, "_model"}, {16'h0, m_out}, {16'h0, expv});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; arith = 1'b0; data_in = '0; shamt = '0;
    #2;
    chk("por_state", {29'h0, busy, done, 1'b0}, 32'h0);
    chk("por_out", {16'h0, data_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op(16'hAAAA, 5'd1,  1'b0, 16'h5555, 1,  1'b0, "srl1");
    op(16'hF000, 5'd4,  1'b1, 16'hFF00, 4,  1'b0, "sra4");
    op(16'hF000, 5'd4,  1'b0, 16'h0F00, 4,  1'b0, "srl4");
    op(16'h1234, 5'd0,  1'b0, 16'h1234, 0,  1'b0, "zero");
    op(16'hFFFF, 5'd20, 1'b0, 16'h0000, 16, 1'b0, "sat_srl");
    op(16'h8000, 5'd31, 1'b1, 16'hFFFF, 16, 1'b0, "sat_sra");
    op(16'h7FFF, 5'd16, 1'b1, 16'h0000, 16, 1'b0, "sat_pos");
    op(16'hC0DE, 5'd6,  1'b1, 16'hFF03, 6,  1'b1, "poke");
    // Back-to-back: second op is presented while done from the first is high.
    op(16'h8421, 5'd2,  1'b0, 16'h2108, 2,  1'b0, "b2b_a");
    op(16'h9000, 5'd3,  1'b1, 16'hF200, 3,  1'b0, "b2b_b");

    // Reset while idle with a non-zero result held.
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("idle_rst", {13'h0, busy, done, 1'b0, data_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-shift aborts with no done pulse.
    data_in = 16'hBEEF; shamt = 5'd8; arith = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_rst", {13'h0, busy, done, 1'b0, data_out}, 32'h0);
    begin
      int seen = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("abort_nodone", 32'(seen), 32'h0);
    end

    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom % 4) == 0;
      data_in = 16'($urandom);
      shamt   = ($urandom % 3 == 0) ? 5'(16 + $urandom % 16) : 5'($urandom % 16);
      arith   = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
